// File: rtl/truth_table_sweep.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweep
// Purpose  : Drives all 8 vectors into a 3-input circuit, captures its truth
//            table and compares it against an expected table. The optional
//            macro TRUTH_TABLE_SWEEP_SYNC_EN adds a 2-flop input synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweep #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected_tt,
    input  logic       dut_out,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] measured_tt,
    output logic [7:0] mismatch_mask,
    output logic [3:0] err_count,
    output logic       pass
);

`ifdef TRUTH_TABLE_SWEEP_SYNC_EN
    localparam int HOLD_CYCLES = SETTLE_CYCLES + 2;
`else
    localparam int HOLD_CYCLES = SETTLE_CYCLES;
`endif
    localparam int              CNT_W    = 9;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       exp_q, exp_d;
    logic [7:0]       meas_q, meas_d;
    logic [7:0]       mask_q, mask_d;
    logic [3:0]       err_q, err_d;
    logic             pass_q, pass_d;
    logic             sample_w;

`ifdef TRUTH_TABLE_SWEEP_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], dut_out};
        end
    end

    assign sample_w = sync_q[1];
`else
    assign sample_w = dut_out;
`endif

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 8; k++) begin
            r = r + {3'b000, v[k]};
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        meas_d  = meas_q;
        mask_d  = mask_q;
        err_d   = err_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_HOLD;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    exp_d   = expected_tt;
                    meas_d  = 8'h00;
                    mask_d  = 8'h00;
                    err_d   = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    mask_d  = 8'h00;
                    err_d   = 4'd0;
                    pass_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    meas_d[3'd7 - idx_q] = sample_w;
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        // Results are formed from the final capture so they
                        // are already valid during the done cycle.
                        state_d = S_FINISH;
                        mask_d  = meas_d ^ exp_q;
                        err_d   = popcount8(meas_d ^ exp_q);
                        pass_d  = ((meas_d ^ exp_q) == 8'h00);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            exp_q   <= 8'h00;
            meas_q  <= 8'h00;
            mask_q  <= 8'h00;
            err_q   <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            meas_q  <= meas_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign busy                        = (state_q == S_HOLD);
    assign done                        = (state_q == S_FINISH);
    assign {dut_in1, dut_in2, dut_in3} = busy ? idx_q : 3'b000;
    assign measured_tt                 = meas_q;
    assign mismatch_mask               = mask_q;
    assign err_count                   = err_q;
    assign pass                        = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweep.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sweep
// Purpose  : Self-checking bench: table vectors, corner sequences, random sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweep;

    localparam int SETTLE_CYCLES = 4;
`ifdef TRUTH_TABLE_SWEEP_SYNC_EN
    localparam int H = SETTLE_CYCLES + 2;
`else
    localparam int H = SETTLE_CYCLES;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] expected_tt;
    logic       dut_out;
    logic       dut_in1, dut_in2, dut_in3;
    logic       busy, done;
    logic [7:0] measured_tt, mismatch_mask;
    logic [3:0] err_count;
    logic       pass;
    logic [7:0] cut_tt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] cut;
        logic [7:0] exp;
        logic [7:0] meas;
        logic [7:0] mask;
        logic [3:0] err;
        logic       pass;
    } vec_t;

    vec_t tbl[3];

    always #5 clk = ~clk;

    // Circuit under test modelled as a truth-table ROM indexed by the drive vector.
    assign dut_out = cut_tt[3'd7 - {dut_in1, dut_in2, dut_in3}];

    truth_table_sweep #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .expected_tt  (expected_tt),
        .dut_out      (dut_out),
        .dut_in1      (dut_in1),
        .dut_in2      (dut_in2),
        .dut_in3      (dut_in3),
        .busy         (busy),
        .done         (done),
        .measured_tt  (measured_tt),
        .mismatch_mask(mismatch_mask),
        .err_count    (err_count),
        .pass         (pass)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t model(input logic [7:0] cut, input logic [7:0] exp);
        vec_t v;
        v.cut  = cut;
        v.exp  = exp;
        v.meas = cut;
        v.mask = cut ^ exp;
        v.err  = 4'($countones(cut ^ exp));
        v.pass = (cut == exp);
        return v;
    endfunction

    // Launch a sweep; on return the bench sits in cycle T+1 (edge T accepted start).
    task automatic launch(input logic [7:0] cut, input logic [7:0] exp);
        @(negedge clk);
        cut_tt      = cut;
        expected_tt = exp;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic sweep(input vec_t v, input bit poke_start, input bit abort_in_finish);
        int terr;
        int first7;
        int n7;
        terr   = 0;
        first7 = -1;
        n7     = 0;
        launch(v.cut, v.exp);
        for (int c = 1; c <= 8 * H + 1; c++) begin
            if (c > 1) @(negedge clk);
            start = poke_start && (c == 10);
            if (busy !== (c <= 8 * H)) terr++;
            if (done !== (c == 8 * H + 1)) terr++;
            if ({dut_in1, dut_in2, dut_in3} !== ((c <= 8 * H) ? 3'((c - 1) / H) : 3'd0)) terr++;
            if ({dut_in1, dut_in2, dut_in3} === 3'd7) begin
                if (first7 < 0) first7 = c;
                n7++;
            end
            if (c == 8 * H + 1) begin
                chk("done_meas", 32'(measured_tt), 32'(v.meas));
                chk("done_mask", 32'(mismatch_mask), 32'(v.mask));
                chk("done_err", 32'(err_count), 32'(v.err));
                chk("done_pass", 32'(pass), 32'(v.pass));
                abort = abort_in_finish;
            end
        end
        chk("sweep_timing_errs", 32'(terr), 32'd0);
        chk("vec7_first_cycle", 32'(first7), 32'(7 * H + 1));
        chk("vec7_cycles", 32'(n7), 32'(H));
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("idle_after_done", {29'd0, busy, done, dut_in1 | dut_in2 | dut_in3}, 32'd0);
        chk("hold_results", {11'd0, measured_tt, mismatch_mask, err_count, pass},
            {11'd0, v.meas, v.mask, v.err, v.pass});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        vec_t r;
        tbl[0] = '{8'h8E, 8'h8E, 8'h8E, 8'h00, 4'd0, 1'b1};
        tbl[1] = '{8'h8E, 8'h8F, 8'h8E, 8'h01, 4'd1, 1'b0};
        tbl[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 4'd8, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; expected_tt = 8'h00; cut_tt = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {6'd0, busy, done, dut_in1, dut_in2, dut_in3, measured_tt,
            mismatch_mask, err_count, pass}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) sweep(tbl[i], 1'b0, 1'b0);

        // start pulsed mid-sweep, then abort sampled in FINISH: both ignored
        sweep(tbl[0], 1'b1, 1'b0);
        sweep(tbl[1], 1'b0, 1'b1);

        // abort while vector 3 is driven
        launch(8'h8E, 8'h8E);
        for (int c = 1; c < 3 * H + 2; c++) @(negedge clk);
        chk("abort_vec3_drive", 32'({dut_in1, dut_in2, dut_in3}), 32'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {29'd0, busy, done, dut_in1 | dut_in2 | dut_in3}, 32'd0);
        chk("abort_meas", 32'(measured_tt), 32'(8'h8E & 8'hE0));
        chk("abort_results", {19'd0, mismatch_mask, err_count, pass}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 8 * H + 4; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        sweep(tbl[0], 1'b0, 1'b0);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {30'd0, busy, done}, 32'd0);

        // rst at vector 5 mid-sweep
        launch(8'h8E, 8'h8E);
        for (int c = 1; c < 5 * H + 2; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_outputs", {6'd0, busy, done, dut_in1, dut_in2, dut_in3, measured_tt,
            mismatch_mask, err_count, pass}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 3 * H; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("rst_mid_idle", 32'(ndone), 32'd0);

        // start coincident with rst
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_with_rst", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] c8;
            logic [7:0] e8;
            c8 = 8'($urandom);
            e8 = ($urandom_range(0, 2) == 0) ? c8 : 8'($urandom);
            r  = model(c8, e8);
            sweep(r, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, legal range 1..255; the number of cycles each input vector is held before its sample is taken.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin a sweep; sampled in IDLE only.
REQ-005 abort  input  1  terminate the sweep in progress.
REQ-006 expected_tt  input  8  expected truth table; latched on an accepted start.
REQ-007 dut_out  input  1  output of the 3-input circuit under test.
REQ-008 dut_in1, dut_in2, dut_in3  output  1 each  drive the circuit-under-test inputs.
REQ-009 busy  output  1  high while a sweep is active.
REQ-010 done  output  1  one-cycle pulse when results become valid.
REQ-011 measured_tt  output  8  captured truth table.
REQ-012 mismatch_mask  output  8  measured_tt XOR latched expected_tt.
REQ-013 err_count  output  4  popcount of mismatch_mask (range 0..8).
REQ-014 pass  output  1  high when the last completed sweep had zero mismatches.

Function
REQ-015 Vector index i (0..7) SHALL map as {dut_in1,dut_in2,dut_in3} = i, with dut_in1 as the MSB; the result bit for vector i SHALL be tt[7-i], so the all-zero vector maps to bit 7.
REQ-016 The FSM SHALL have the states IDLE, HOLD and FINISH; reset state is IDLE.
REQ-017 IDLE: dut_in* = 000 and busy = 0; start=1 with abort=0 SHALL transition to HOLD with i=0, latch expected_tt, and clear measured_tt, mismatch_mask, err_count and pass.
REQ-018 HOLD: vector i is driven for exactly H cycles (H = SETTLE_CYCLES); the settle counter runs 0..H-1.
REQ-019 On the cycle with counter = H-1, dut_out SHALL be captured into measured_tt[7-i]; if i<7, i increments and the counter clears; if i=7, the FSM goes to FINISH.
REQ-020 FINISH, one cycle: mismatch_mask, err_count and pass SHALL be registered; done=1, busy=0, dut_in*=000; the FSM then returns to IDLE.
REQ-021 busy SHALL be 1 exactly during HOLD; start at edge T gives busy over cycles T+1..T+8H and done at T+8H+1.
REQ-022 Results SHALL hold their values until the next accepted start or reset.
REQ-023 start while busy SHALL be ignored.
REQ-024 abort in HOLD SHALL force IDLE on the next edge with no done pulse; partial measured_tt is retained; mismatch_mask=0, err_count=0, pass=0.
REQ-025 If start and abort are both high in IDLE, abort wins and no sweep starts.
REQ-026 abort in FINISH SHALL be ignored, and done still pulses.

Reset
REQ-027 rst=1 at any edge, including mid-sweep, SHALL force IDLE and i=0, clear the counter, and zero every output: dut_in*, busy, done, measured_tt, mismatch_mask, err_count, pass.
REQ-028 The latched expected_tt SHALL be cleared to 0x00 on reset.
REQ-029 A start coincident with rst SHALL be ignored.

Configuration
REQ-030 Macro TRUTH_TABLE_SWEEP_SYNC_EN defined: dut_out SHALL pass through a two-flop synchronizer (reset to 0) before capture, and H = SETTLE_CYCLES+2.
REQ-031 Macro not defined: dut_out SHALL be sampled directly, with H = SETTLE_CYCLES, and the synchronizer flops SHALL be absent.

Verification
REQ-032 Circuit-under-test = NOR network implementing 0x8E, expected_tt=0x8E, SETTLE_CYCLES=4, start at T -> done at T+33, measured_tt=0x8E, mismatch_mask=0x00, err_count=0, pass=1.
REQ-033 Same circuit, expected_tt=0x8F -> mismatch_mask=0x01, err_count=1, pass=0; check the vector 111 drive window is cycles T+29..T+32.
REQ-034 dut_out tied 0, expected_tt=0xFF -> measured_tt=0x00, mismatch_mask=0xFF, err_count=8, pass=0.
REQ-035 abort asserted while vector 3 is driven -> busy=0 and dut_in*=000 next cycle, no done pulse, pass=0, measured_tt bits 7..5 retained; a new start then gives a full sweep.
REQ-036 start pulsed while busy -> no effect on timing; rst at vector 5 -> all outputs 0 next cycle, and the FSM is in IDLE.
REQ-037 TRUTH_TABLE_SWEEP_SYNC_EN build, SETTLE_CYCLES=4 -> done at T+49, and results match REQ-032.
